// File: rtl/i2c_eeprom_pkg.sv
// rtl/i2c_eeprom_pkg.sv - shared state encoding and bus constants for the I2C EEPROM target
package i2c_eeprom_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        ACK_DEV,
        WORD_ADDR,
        ACK_WORD,
        WRITE_DATA,
        ACK_DATA,
        READ_DATA,
        READ_ACK
    } i2c_state_e;

    localparam logic I2C_RW_READ = 1'b1;
    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;

endpackage

// File: rtl/i2c_eeprom_if.sv
// rtl/i2c_eeprom_if.sv - synchronized SCL/SDA levels and edge pulses as seen by the target logic
interface i2c_eeprom_if;

    logic scl;
    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic sda_rise;
    logic sda_fall;

    modport master (output scl, sda, scl_rise, scl_fall, sda_rise, sda_fall);
    modport slave  (input  scl, sda, scl_rise, scl_fall, sda_rise, sda_fall);

endinterface

// File: rtl/i2c_eeprom_edge_sync.sv
// rtl/i2c_eeprom_edge_sync.sv - i2c_edge_sync: two-flop synchronizers plus rise/fall pulses per line
module i2c_edge_sync (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         scl_raw,
    input  logic         sda_raw,
    i2c_eeprom_if.master bus
);

    // Bit 1 = SCL, bit 0 = SDA; reset to the idle-high bus level so no edge fires on release.
    logic [1:0] meta;
    logic [1:0] sync;
    logic [1:0] prev;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta <= 2'b11;
            sync <= 2'b11;
            prev <= 2'b11;
        end else begin
            meta <= {scl_raw, sda_raw};
            sync <= meta;
            prev <= sync;
        end
    end

    assign bus.scl      = sync[1];
    assign bus.sda      = sync[0];
    assign bus.scl_rise = sync[1] & ~prev[1];
    assign bus.scl_fall = ~sync[1] & prev[1];
    assign bus.sda_rise = sync[0] & ~prev[0];
    assign bus.sda_fall = ~sync[0] & prev[0];

endmodule

// File: rtl/i2c_eeprom.sv
// rtl/i2c_eeprom.sv - I2C target emulating a 256-byte EEPROM with one word-address byte
module i2c_eeprom
    import i2c_eeprom_pkg::*;
#(
    parameter logic [6:0] ADDRESS   = 7'b1010_000,
    parameter int         MEM_DEPTH = 256
) (
    input logic clk_i,
    input logic rst_ni,
    inout wire  scl_io,
    inout wire  sda_io
);

    i2c_eeprom_if bus ();

    i2c_edge_sync u_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .scl_raw (scl_io),
        .sda_raw (sda_io),
        .bus     (bus)
    );

    i2c_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       oe_q, oe_d;
    logic       rw_q, rw_d;
    logic       mem_we;
    logic [7:0] rx_byte;
    logic [7:0] rd_byte;
    logic       start, stop;

    // Stored inverted so that all-zero power-up flops read back as 8'hFF.
    logic [7:0] mem_n [MEM_DEPTH];

    assign start   = bus.sda_fall & bus.scl;
    assign stop    = bus.sda_rise & bus.scl;
    assign rx_byte = {shift_q[6:0], bus.sda};
    assign rd_byte = ~mem_n[ptr_q];
    assign sda_io  = oe_q ? 1'b0 : 1'bz;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            shift_q <= 8'd0;
            ptr_q   <= 8'd0;
            oe_q    <= 1'b0;
            rw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            ptr_q   <= ptr_d;
            oe_q    <= oe_d;
            rw_q    <= rw_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) mem_n[ptr_q] <= ~rx_byte;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        ptr_d   = ptr_q;
        oe_d    = oe_q;
        rw_d    = rw_q;
        mem_we  = 1'b0;
        if (start) begin
            state_d = DEV_ADDR;
            cnt_d   = 3'd0;
            oe_d    = 1'b0;
        end else if (stop) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            oe_d    = 1'b0;
        end else begin
            unique case (state_q)
                DEV_ADDR, WORD_ADDR, WRITE_DATA: begin
                    if (bus.scl_rise) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (state_q == DEV_ADDR) begin
                                if (shift_q[6:0] == ADDRESS) begin
                                    state_d = ACK_DEV;
                                    rw_d    = bus.sda;
                                end else begin
                                    state_d = IDLE;
                                end
                            end else if (state_q == WORD_ADDR) begin
                                ptr_d   = rx_byte;
                                state_d = ACK_WORD;
                            end else begin
                                mem_we  = 1'b1;
                                ptr_d   = ptr_q + 8'd1;
                                state_d = ACK_DATA;
                            end
                        end
                    end
                end
                // cnt_q = 0: awaiting the fall after bit 8; cnt_q = 1: awaiting the fall after bit 9.
                ACK_DEV, ACK_WORD, ACK_DATA: begin
                    if (bus.scl_fall) begin
                        if (cnt_q == 3'd0) begin
                            oe_d  = ~I2C_ACK;
                            cnt_d = 3'd1;
                        end else begin
                            oe_d  = 1'b0;
                            cnt_d = 3'd0;
                            if (state_q == ACK_DEV && rw_q == I2C_RW_READ) begin
                                state_d = READ_DATA;
                                shift_d = rd_byte;
                                oe_d    = ~rd_byte[7];
                            end else if (state_q == ACK_DEV) begin
                                state_d = WORD_ADDR;
                            end else begin
                                state_d = WRITE_DATA;
                            end
                        end
                    end
                end
                READ_DATA: begin
                    if (bus.scl_rise) begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_d = READ_ACK;
                            ptr_d   = ptr_q + 8'd1;
                        end
                    end else if (bus.scl_fall) begin
                        oe_d    = ~shift_q[6];
                        shift_d = {shift_q[6:0], 1'b0};
                    end
                end
                READ_ACK: begin
                    if (bus.scl_fall) begin
                        if (cnt_q == 3'd0) begin
                            oe_d = 1'b0;
                        end else begin
                            state_d = READ_DATA;
                            cnt_d   = 3'd0;
                            shift_d = rd_byte;
                            oe_d    = ~rd_byte[7];
                        end
                    end else if (bus.scl_rise) begin
                        if (bus.sda == I2C_NACK) begin
                            state_d = IDLE;
                            oe_d    = 1'b0;
                        end else begin
                            cnt_d = 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_eeprom.sv
// tb/tb_i2c_eeprom.sv - randomized scoreboard bench for i2c_eeprom against a byte-array model
module tb_i2c_eeprom;

    localparam int Q = 50;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    i2c_eeprom_if bif ();

    wire scl_w;
    wire sda_w;
    pullup (sda_w);
    assign scl_w = bif.scl;
    assign sda_w = bif.sda ? 1'bz : 1'b0;

    i2c_eeprom dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .scl_io (scl_w),
        .sda_io (sda_w)
    );

    exp_t       exp_q[$];
    logic [7:0] act_q[$];
    int         total = 0;
    int         bad = 0;
    logic [7:0] model_mem [256];
    int         model_ptr = 0;

    task automatic expect_val(input string n, input logic [7:0] v);
        exp_t e;
        e.name = n;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic [7:0] v);
        act_q.push_back(v);
    endtask

    initial begin
        exp_t       e;
        logic [7:0] a;
        forever begin
            wait (act_q.size() > 0);
            a = act_q.pop_front();
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_obs got=%0h want=none", a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e.val) begin
                    bad++;
                    $display("FAIL %s got=%0h want=%0h", e.name, a, e.val);
                end
            end
        end
    end

    task automatic start_c();
        bif.sda = 1'b1; #Q;
        bif.scl = 1'b1; #Q;
        bif.sda = 1'b0; #Q;
        bif.scl = 1'b0; #Q;
    endtask

    task automatic stop_c();
        bif.sda = 1'b0; #Q;
        bif.scl = 1'b1; #Q;
        bif.sda = 1'b1; #Q;
    endtask

    task automatic wbit(input logic b);
        bif.sda = b; #Q;
        bif.scl = 1'b1; #(2*Q);
        bif.scl = 1'b0; #Q;
    endtask

    task automatic rbit(output logic b);
        bif.sda = 1'b1; #Q;
        bif.scl = 1'b1; #Q;
        b = sda_w; #Q;
        bif.scl = 1'b0; #Q;
    endtask

    task automatic send(input logic [7:0] d, input logic want_ack, input string n);
        logic a;
        expect_val(n, {7'd0, want_ack});
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(a);
        observe({7'd0, a});
    endtask

    task automatic recv(input logic ack, input string n);
        logic [7:0] d;
        logic       b;
        expect_val(n, model_mem[model_ptr]);
        model_ptr = (model_ptr + 1) % 256;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        observe(d);
        wbit(ack);
    endtask

    task automatic check_idle(input string n);
        expect_val(n, 8'd1);
        observe({7'd0, sda_w});
    endtask

    task automatic write_block(input int addr, input logic [7:0] dq[$]);
        start_c();
        send(8'hA0, 1'b0, "ack_dev_w");
        send(addr[7:0], 1'b0, "ack_word");
        model_ptr = addr;
        foreach (dq[i]) begin
            send(dq[i], 1'b0, "ack_wdata");
            model_mem[model_ptr] = dq[i];
            model_ptr = (model_ptr + 1) % 256;
        end
        stop_c();
    endtask

    task automatic cur_read(input int n);
        start_c();
        send(8'hA1, 1'b0, "ack_dev_r");
        for (int i = 0; i < n; i++) recv(i == n - 1, "rdata");
        stop_c();
        check_idle("sda_released");
    endtask

    task automatic read_block(input int addr, input int n);
        start_c();
        send(8'hA0, 1'b0, "ack_dev_w");
        send(addr[7:0], 1'b0, "ack_word");
        model_ptr = addr;
        start_c();
        send(8'hA1, 1'b0, "ack_dev_r");
        for (int i = 0; i < n; i++) recv(i == n - 1, "rdata");
        stop_c();
        check_idle("sda_released");
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] dq[$];
        int         addr;
        int         n;
        foreach (model_mem[i]) model_mem[i] = 8'hFF;
        bif.scl = 1'b1;
        bif.sda = 1'b1;
        #52;
        rst_ni = 1'b1;
        #Q;
        check_idle("reset_sda");

        read_block(8'h80, 1);

        dq = '{8'h5A};
        write_block(8'h10, dq);
        read_block(8'h10, 1);

        dq = '{8'h11, 8'h22, 8'h33};
        write_block(8'hFE, dq);
        read_block(8'hFE, 3);

        start_c();
        send(8'hA2, 1'b1, "nack_mismatch_w");
        stop_c();
        start_c();
        send(8'hA3, 1'b1, "nack_mismatch_r");
        stop_c();
        start_c();
        send(8'hA0, 1'b0, "ack_after_mismatch");
        stop_c();

        dq = '{8'hC3};
        write_block(8'h30, dq);
        start_c();
        send(8'hA0, 1'b0, "ack_dev_w");
        send(8'h30, 1'b0, "ack_word");
        model_ptr = 8'h30;
        for (int i = 0; i < 4; i++) wbit(i[0]);
        stop_c();
        read_block(8'h30, 1);

        for (int t = 0; t < 8; t++) begin
            addr = $urandom_range(0, 255);
            n = $urandom_range(1, 4);
            dq.delete();
            for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
            write_block(addr, dq);
            read_block(addr, n);
            cur_read(1);
        end

        dq = '{8'h00};
        write_block(8'h40, dq);
        start_c();
        send(8'hA0, 1'b0, "ack_dev_w");
        send(8'h40, 1'b0, "ack_word");
        start_c();
        send(8'hA1, 1'b0, "ack_dev_r");
        expect_val("rd_bit7_driven", 8'd0);
        observe({7'd0, sda_w});
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        expect_val("rst_release", 8'd1);
        observe({7'd0, sda_w});
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        model_ptr = 0;
        #Q;
        stop_c();
        cur_read(1);

        #(10*Q);
        total++;
        if (exp_q.size() != 0 || act_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d/%0d want=0/0", exp_q.size(), act_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
